// File: rtl/oscope_decimator.sv
// oscope_decimator
//   Reduces the raw ADC stream by a factor N = 2^min(rate,MAX_LOG2). Each
//   window of N valid samples becomes one signed DW-bit sample. The window is
//   reduced by one of four modes: first sample, mean, maximum or minimum.
//   The result is presented on dout together with a one-cycle en strobe.
//
// Ports
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   adc_d    signed ADC sample
//   adc_vld  adc_d valid this cycle
//   rate     log2 decimation factor; values above MAX_LOG2 clamp
//   mode     0 first, 1 mean, 2 max, 3 min
//   sync     synchronous window restart; also clears ovr
//   dout     decimated sample, held between strobes
//   en       one-cycle strobe marking a new dout
//   ovr      sticky flag: a valid sample arrived in the first cycle after reset
module oscope_decimator #(
    parameter int MAX_LOG2 = 10,
    parameter int DW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] adc_d,
    input  logic          adc_vld,
    input  logic [3:0]    rate,
    input  logic [1:0]    mode,
    input  logic          sync,
    output logic [DW-1:0] dout,
    output logic          en,
    output logic          ovr
);
    localparam int AW = DW + MAX_LOG2;   // accumulator width; a full window cannot overflow it
    localparam int CW = MAX_LOG2 + 1;    // counter must be able to reach 2^MAX_LOG2

    typedef enum logic {IDLE, ACC} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic signed [AW-1:0] acc;
    logic [3:0]           rate_q;
    logic [1:0]           mode_q;
    logic                 first;   // high in the first cycle after reset release

    logic [3:0]           rate_clamp;
    logic [3:0]           cur_rate;
    logic [1:0]           cur_mode;
    logic signed [AW-1:0] sample_ext;
    logic signed [AW-1:0] acc_nxt;
    logic [CW-1:0]        cnt_nxt;
    logic [CW-1:0]        n_target;
    logic                 closing;
    logic [DW-1:0]        avg;
    logic [DW-1:0]        result;
    logic                 idle;

    assign idle       = (state == IDLE);
    assign rate_clamp = (rate > 4'(MAX_LOG2)) ? 4'(MAX_LOG2) : rate;
    // The first sample of a window uses the live rate/mode, which are latched with it
    assign cur_rate   = idle ? rate_clamp : rate_q;
    assign cur_mode   = idle ? mode : mode_q;
    assign sample_ext = {{MAX_LOG2{adc_d[DW-1]}}, adc_d};
    assign cnt_nxt    = idle ? CW'(1) : cnt + CW'(1);
    assign n_target   = CW'(1) << cur_rate;
    assign closing    = adc_vld && (cnt_nxt == n_target);
    // Arithmetic shift floors toward -inf, matching the intended mean rounding
    assign avg        = DW'(acc_nxt >>> cur_rate);

    always_comb begin
        acc_nxt = acc;
        if (idle) begin
            acc_nxt = sample_ext;
        end else begin
            case (mode_q)
                2'd0:    acc_nxt = acc;
                2'd1:    acc_nxt = acc + sample_ext;
                2'd2:    acc_nxt = (sample_ext > acc) ? sample_ext : acc;
                default: acc_nxt = (sample_ext < acc) ? sample_ext : acc;
            endcase
        end
    end

    always_comb begin
        result = acc_nxt[DW-1:0];
        if (cur_mode == 2'd1)
            result = avg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            rate_q <= '0;
            mode_q <= '0;
            dout   <= '0;
            en     <= 1'b0;
            ovr    <= 1'b0;
            first  <= 1'b1;
        end else begin
            en    <= 1'b0;
            first <= 1'b0;
            if (sync) begin
                // sync wins over a coincident sample, which is discarded
                state <= IDLE;
                cnt   <= '0;
                acc   <= '0;
                ovr   <= 1'b0;
            end else begin
                if (first && adc_vld)
                    ovr <= 1'b1;
                if (adc_vld) begin
                    if (idle) begin
                        rate_q <= rate_clamp;
                        mode_q <= mode;
                    end
                    acc <= acc_nxt;
                    if (closing) begin
                        state <= IDLE;
                        cnt   <= '0;
                        dout  <= result;
                        en    <= 1'b1;
                    end else begin
                        state <= ACC;
                        cnt   <= cnt_nxt;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_oscope_decimator.sv
module tb_oscope_decimator;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] adc_d = '0;
    logic       adc_vld = 1'b0;
    logic [3:0] rate = '0;
    logic [1:0] mode = '0;
    logic       sync = 1'b0;
    logic [7:0] dout;
    logic       en;
    logic       ovr;

    int checks = 0;
    int errors = 0;

    oscope_decimator #(.MAX_LOG2(10), .DW(8)) dut (
        .clk(clk), .rst(rst), .adc_d(adc_d), .adc_vld(adc_vld), .rate(rate),
        .mode(mode), .sync(sync), .dout(dout), .en(en), .ovr(ovr)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are then sampled 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        adc_vld = v;
        adc_d   = d;
        tick();
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({en, dout, ovr} !== 10'b0) begin
            errors++;
            $display("FAIL reset_state: en=%0b dout=%0d ovr=%0b expected 0/0/0", en, dout, ovr);
        end
        #10 rst = 1'b0;   // released between edges with adc_vld low
        tick(); tick();
        checks++;
        if ({en, ovr} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release_quiet: en=%0b ovr=%0b expected 0/0", en, ovr);
        end
    endtask

    task automatic test_rate0_stream();
        rate = 4'd0; mode = 2'd0;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 8'(i));
            checks++;
            if ({en, dout} !== {1'b1, 8'(i)}) begin
                errors++;
                $display("FAIL rate0_sample%0d: en=%0b dout=%0d expected 1/%0d", i, en, dout, i);
            end
        end
        drive(1'b0, 8'd99);
        checks++;
        if ({en, dout} !== {1'b0, 8'd3}) begin
            errors++;
            $display("FAIL rate0_hold: en=%0b dout=%0d expected 0/3", en, dout);
        end
    endtask

    task automatic test_average();
        logic bad;
        rate = 4'd2; mode = 2'd1;
        bad = 1'b0;
        drive(1'b1, 8'd10); bad |= en;
        drive(1'b1, 8'd11); bad |= en;
        drive(1'b1, 8'd12); bad |= en;
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL avg_early_en: en seen=%0b expected 0", bad);
        end
        drive(1'b1, 8'hFB);   // -5
        checks++;
        if ({en, dout} !== {1'b1, 8'd7}) begin
            errors++;
            $display("FAIL avg_mean: en=%0b dout=%0d expected 1/7", en, dout);
        end
        drive(1'b1, 8'hFF);
        checks++;
        if (en !== 1'b0) begin
            errors++;
            $display("FAIL avg_en_width: en=%0b expected 0", en);
        end
        drive(1'b1, 8'hFF);
        drive(1'b1, 8'hFF);
        drive(1'b1, 8'hFE);
        checks++;
        if ({en, dout} !== {1'b1, 8'hFE}) begin
            errors++;
            $display("FAIL avg_floor: en=%0b dout=%0h expected 1/fe", en, dout);
        end
    endtask

    task automatic test_peak();
        int s[8] = '{-128, 5, 127, 0, -3, 9, -1, 2};
        logic [7:0] exp_v[2] = '{8'h7F, 8'h80};
        logic bad;
        rate = 4'd3;
        for (int m = 0; m < 2; m++) begin
            mode = 2'(m + 2);
            bad  = 1'b0;
            for (int i = 0; i < 8; i++) begin
                drive(1'b1, 8'(s[i]));
                if (i < 7) bad |= en;
            end
            checks++;
            if ({bad, en, dout} !== {1'b0, 1'b1, exp_v[m]}) begin
                errors++;
                $display("FAIL peak_mode%0d: early=%0b en=%0b dout=%0h expected 0/1/%0h",
                         m + 2, bad, en, dout, exp_v[m]);
            end
        end
        drive(1'b0, 8'd0);
    endtask

    task automatic test_gaps_rate_change();
        logic bad;
        rate = 4'd2; mode = 2'd1;
        bad = 1'b0;
        drive(1'b1, 8'd4);  bad |= en;
        drive(1'b0, 8'd77); bad |= en;
        drive(1'b1, 8'd8);  bad |= en;
        drive(1'b0, 8'd77); bad |= en;
        rate = 4'd0;        // must not affect the open window
        drive(1'b1, 8'd12); bad |= en;
        drive(1'b0, 8'd77); bad |= en;
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL gap_early_en: en seen=%0b expected 0", bad);
        end
        drive(1'b1, 8'd16);
        checks++;
        if ({en, dout} !== {1'b1, 8'd10}) begin
            errors++;
            $display("FAIL gap_mean: en=%0b dout=%0d expected 1/10", en, dout);
        end
        drive(1'b1, 8'd33);  // next window takes rate 0
        checks++;
        if ({en, dout} !== {1'b1, 8'd33}) begin
            errors++;
            $display("FAIL gap_new_rate: en=%0b dout=%0d expected 1/33", en, dout);
        end
        drive(1'b0, 8'd0);
    endtask

    task automatic test_sync();
        logic bad;
        rate = 4'd2; mode = 2'd1;
        bad = 1'b0;
        drive(1'b1, 8'd100); bad |= en;
        drive(1'b1, 8'd100); bad |= en;
        sync = 1'b1;
        drive(1'b1, 8'd100); bad |= en;
        sync = 1'b0;
        drive(1'b1, 8'd1); bad |= en;
        drive(1'b1, 8'd2); bad |= en;
        drive(1'b1, 8'd3); bad |= en;
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL sync_no_en: en seen=%0b expected 0", bad);
        end
        drive(1'b1, 8'd6);
        checks++;
        if ({en, dout} !== {1'b1, 8'd3}) begin
            errors++;
            $display("FAIL sync_mean: en=%0b dout=%0d expected 1/3", en, dout);
        end
        drive(1'b0, 8'd0);
    endtask

    task automatic test_clamp();
        logic bad;
        rate = 4'd15; mode = 2'd1;
        bad = 1'b0;
        for (int i = 0; i < 1023; i++) begin
            drive(1'b1, 8'd5);
            bad |= en;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL clamp_early_en: en seen=%0b expected 0", bad);
        end
        drive(1'b1, 8'd5);
        checks++;
        if ({en, dout} !== {1'b1, 8'd5}) begin
            errors++;
            $display("FAIL clamp_close: en=%0b dout=%0d expected 1/5", en, dout);
        end
        drive(1'b0, 8'd0);
    endtask

    task automatic test_async_reset();
        rate = 4'd2; mode = 2'd1;
        drive(1'b1, 8'd50);
        drive(1'b1, 8'd50);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({en, dout, ovr} !== 10'b0) begin
            errors++;
            $display("FAIL async_rst: en=%0b dout=%0d ovr=%0b expected 0/0/0", en, dout, ovr);
        end
        #2;
        adc_vld = 1'b1; adc_d = 8'd20; rst = 1'b0;
        tick();
        checks++;
        if ({en, ovr} !== 2'b01) begin
            errors++;
            $display("FAIL ovr_set: en=%0b ovr=%0b expected 0/1", en, ovr);
        end
        drive(1'b1, 8'd20);
        drive(1'b1, 8'd20);
        drive(1'b1, 8'd24);
        checks++;
        if ({en, dout, ovr} !== {1'b1, 8'd21, 1'b1}) begin
            errors++;
            $display("FAIL post_rst_mean: en=%0b dout=%0d ovr=%0b expected 1/21/1", en, dout, ovr);
        end
        sync = 1'b1;
        drive(1'b0, 8'd0);
        sync = 1'b0;
        checks++;
        if ({ovr, dout} !== {1'b0, 8'd21}) begin
            errors++;
            $display("FAIL ovr_clear: ovr=%0b dout=%0d expected 0/21", ovr, dout);
        end
    endtask

    initial begin
        test_reset();
        test_rate0_stream();
        test_average();
        test_peak();
        test_gaps_rate_change();
        test_sync();
        test_clamp();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
